ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX register outputs and produces the registered EX/MEM fields for the MEM stage.
- Contains:
  - ALU control decode;
  - the 32-bit ALU;
  - branch-target adder;
  - an iterative 32-cycle multiplier with HI/LO registers.
- Asserts o_stall to freeze IF/ID/EX while a multiply is in flight.

Parameters:
- DATA_W, 32, datapath width. Only 32 is supported. The multiplier count width is derived from it.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  ID/EX slot holds a real instruction.
- i_flush  in  1  branch taken in MEM. Squash the current EX instruction.
- i_MemtoReg, i_MemWrite, i_MemRead, i_Branch, i_ALUSrc, i_RegDst, i_RegWrite  in  1 each  control from ID/EX.
- i_ALUOp  in  2  00 add, 01 sub, 10 R-type (use funct), 11 add.
- i_PCplus4  in  32  PC+4.
- i_Rdata1, i_Rdata2  in  32 each  rs and rt operands.
- i_signextImmediate  in  32  immediate. Bits [5:0] are funct.
- i_RegDst1, i_RegDst2  in  5 each  rt and rd register numbers.
- o_stall  out  1  hold the PC, IF/ID and ID/EX registers.
- o_valid  out  1  EX/MEM slot valid.
- o_MemtoReg, o_MemWrite, o_MemRead, o_Branch, o_RegWrite  out  1 each  EX/MEM control.
- o_BranchTarget  out  32  PCplus4 + (imm<<2).
- o_Zero  out  1  ALU result == 0.
- o_ALUResult  out  32  ALU, MFHI or MFLO result.
- o_Wdata  out  32  store data (Rdata2).
- o_WriteReg  out  5  RegDst ? rd : rt.

Behaviour:
- **Reset:** all outputs 0, HI = LO = 0, FSM in IDLE. Reset mid-multiply aborts the multiply.
- **EX/MEM register:** all o_* except o_stall are registered, one-cycle latency.
- **Bubble:** o_valid = 0 and every control output = 0. The datapath outputs are don't-care and are held at their previous value.
- **ALU op decode:**
  - ALUOp 00/11: add.
  - ALUOp 01: sub.
  - ALUOp 10, by funct: 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A signed slt, 0x2B unsigned sltu, 0x10 MFHI, 0x12 MFLO, 0x18 MULT, 0x19 MULTU.
  - Any other funct: add.
- **ALU operands:** A = Rdata1. B = ALUSrc ? imm : Rdata2.
- **Arithmetic:** wraps modulo 2^32. No overflow trap.
- **Zero:** o_Zero is computed from the ALU result.
- **FSM states:** IDLE, BUSY, DONE.
  - **IDLE:**
    - A valid MULT/MULTU that is not being flushed latches the operands. o_stall = 1 in that cycle. Next state is BUSY with cnt = 0. EX/MEM receives a bubble.
    - Otherwise the instruction passes through, o_stall = 0.
  - **BUSY:**
    - One shift-add iteration per cycle, 32 cycles (cnt 0..31). o_stall = 1. EX/MEM receives a bubble.
    - On the cnt = 31 edge, HI/LO are written with the 64-bit product. Next state is DONE.
  - **DONE:**
    - o_stall = 0. The MULT retires into EX/MEM with o_valid = 1 and RegWrite as decoded (0). Next state is IDLE.
    - The multiply is not restarted for this instruction.
- **Stall count:** a MULT accepted in cycle t stalls cycles t..t+32 (33 cycles). It retires at t+33.
- **Signed MULT:** multiply the operand magnitudes unsigned, then negate the 64-bit product if the operand signs differ. MULTU uses the raw operands.
- **MFHI/MFLO:** read the current HI/LO. An MFHI in EX immediately after a MULT sees the new value; no forwarding is needed because HI/LO are written before DONE.
- **i_flush:**
  - Any state: the next EX/MEM value is a bubble and o_stall is forced to 0.
  - In BUSY: abort, HI/LO unchanged, next state IDLE.
  - In IDLE with a MULT present: the multiply does not start.
  - Flush has priority over everything except reset.
- **Invalid instruction:** i_valid = 0 produces a bubble. A MULT with i_valid = 0 does not start.

Decomposition:
- Shared package mips_pkg holds:
  - ALUOp encodings;
  - funct constants (ADD, SUB, AND, OR, NOR, SLT, SLTU, MFHI, MFLO, MULT, MULTU);
  - ALU-operation enum;
  - FSM state enum (IDLE, BUSY, DONE).
- One sub-module, mul_iter:
  - Inputs: start, signed flag, operands A/B, abort.
  - Outputs: busy, done pulse, 64-bit product.
  - Contains the counter and the shift-add datapath.
- ALU decode and the EX/MEM register stay in ex_stage.

Test Plan:
1. **Reset during BUSY:** assert i_rst during cycle 10 of a MULT → next cycle o_stall = 0, all outputs 0, HI = LO = 0.
2. **ADD:** ALUOp = 10, funct 0x20, Rdata1 = 0x7FFFFFFF, Rdata2 = 1 → one cycle later o_ALUResult = 0x80000000, o_Zero = 0, o_valid = 1, o_WriteReg = rd.
3. **BEQ path:** ALUOp = 01, Rdata1 = Rdata2 = 5, PCplus4 = 0x100, imm = 3 → o_Zero = 1, o_BranchTarget = 0x10C, o_Branch = 1.
4. **MULT then MFHI/MFLO:** MULT with Rdata1 = 0xFFFFFFFE (-2) and Rdata2 = 3 → o_stall high for exactly 33 cycles, bubbles meanwhile. Then MFLO → 0xFFFFFFFA and MFHI → 0xFFFFFFFF. A following MULTU of 0xFFFFFFFF × 2 gives HI = 1, LO = 0xFFFFFFFE.
5. **Flush during BUSY:** assert i_flush at BUSY cnt = 10 → o_stall = 0 that cycle, next output is a bubble, HI/LO keep their previous values, FSM in IDLE.
6. **SLT vs SLTU:** Rdata1 = 0xFFFFFFFF, Rdata2 = 1 → slt result 1, sltu result 0. Check store path: lw/sw with ALUSrc = 1 and imm = -4 gives Rdata1 - 4 and o_Wdata = Rdata2.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: ALUOp/funct encodings, ALU operation
// enum, multiplier FSM states and the ALU control decoder.
package mips_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_MFHI, ALU_MFLO, ALU_MULT, ALU_MULTU
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

  function automatic alu_op_e alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    case (aluop)
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: op = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: op = ALU_SUB;
          FUNCT_AND:   op = ALU_AND;
          FUNCT_OR:    op = ALU_OR;
          FUNCT_NOR:   op = ALU_NOR;
          FUNCT_SLT:   op = ALU_SLT;
          FUNCT_SLTU:  op = ALU_SLTU;
          FUNCT_MFHI:  op = ALU_MFHI;
          FUNCT_MFLO:  op = ALU_MFLO;
          FUNCT_MULT:  op = ALU_MULT;
          FUNCT_MULTU: op = ALU_MULTU;
          default:     op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle over W cycles.
// Signed operands are multiplied as magnitudes and the product negated at the end.
module mul_iter #(
  parameter int W = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_signed,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic           i_abort,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_product
);
  localparam int CW = $clog2(W);

  logic [W-1:0]   w_mag_a;
  logic [W-1:0]   w_mag_b;
  logic           w_neg;
  logic [2*W-1:0] w_acc_next;

  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           r_neg;
  logic           r_busy;

  assign w_mag_a    = (i_signed && i_a[W-1]) ? -i_a : i_a;
  assign w_mag_b    = (i_signed && i_b[W-1]) ? -i_b : i_b;
  assign w_neg      = i_signed && (i_a[W-1] ^ i_b[W-1]);
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // The product is presented combinationally on the final iteration so the
  // caller can capture it on the same edge that ends the multiply.
  assign o_busy    = r_busy;
  assign o_done    = r_busy && !i_abort && (r_cnt == CW'(W - 1));
  assign o_product = r_neg ? -w_acc_next : w_acc_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{W{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_neg    <= w_neg;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == CW'(W - 1)) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU control and ALU, branch-target adder, HI/LO with an
// iterative multiplier, and the EX/MEM pipeline register.
module ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_flush,
  input  logic              i_MemtoReg,
  input  logic              i_MemWrite,
  input  logic              i_MemRead,
  input  logic              i_Branch,
  input  logic              i_ALUSrc,
  input  logic              i_RegDst,
  input  logic              i_RegWrite,
  input  logic [1:0]        i_ALUOp,
  input  logic [DATA_W-1:0] i_PCplus4,
  input  logic [DATA_W-1:0] i_Rdata1,
  input  logic [DATA_W-1:0] i_Rdata2,
  input  logic [DATA_W-1:0] i_signextImmediate,
  input  logic [4:0]        i_RegDst1,
  input  logic [4:0]        i_RegDst2,
  output logic              o_stall,
  output logic              o_valid,
  output logic              o_MemtoReg,
  output logic              o_MemWrite,
  output logic              o_MemRead,
  output logic              o_Branch,
  output logic              o_RegWrite,
  output logic [DATA_W-1:0] o_BranchTarget,
  output logic              o_Zero,
  output logic [DATA_W-1:0] o_ALUResult,
  output logic [DATA_W-1:0] o_Wdata,
  output logic [4:0]        o_WriteReg
);

  alu_op_e           w_alu_op;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_result;
  logic [DATA_W-1:0] w_branch_target;
  logic              w_is_mul;
  logic              w_mul_start;
  logic              w_mul_abort;
  logic              w_mul_busy;
  logic              w_mul_done;
  logic [2*DATA_W-1:0] w_mul_product;
  logic              w_stall;
  logic              w_bubble;

  mul_state_e        r_state;
  mul_state_e        w_state_next;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  assign w_alu_op        = alu_decode(i_ALUOp, i_signextImmediate[5:0]);
  assign w_alu_b         = i_ALUSrc ? i_signextImmediate : i_Rdata2;
  assign w_is_mul        = (w_alu_op == ALU_MULT) || (w_alu_op == ALU_MULTU);
  assign w_branch_target = i_PCplus4 + {i_signextImmediate[DATA_W-3:0], 2'b00};

  always_comb begin
    w_alu_result = '0;
    case (w_alu_op)
      ALU_ADD:  w_alu_result = i_Rdata1 + w_alu_b;
      ALU_SUB:  w_alu_result = i_Rdata1 - w_alu_b;
      ALU_AND:  w_alu_result = i_Rdata1 & w_alu_b;
      ALU_OR:   w_alu_result = i_Rdata1 | w_alu_b;
      ALU_NOR:  w_alu_result = ~(i_Rdata1 | w_alu_b);
      ALU_SLT:  w_alu_result = {{(DATA_W-1){1'b0}}, $signed(i_Rdata1) < $signed(w_alu_b)};
      ALU_SLTU: w_alu_result = {{(DATA_W-1){1'b0}}, i_Rdata1 < w_alu_b};
      ALU_MFHI: w_alu_result = r_hi;
      ALU_MFLO: w_alu_result = r_lo;
      default:  w_alu_result = '0;
    endcase
  end

  mul_iter #(.W(DATA_W)) u_mul (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (w_mul_start),
    .i_signed  (w_alu_op == ALU_MULT),
    .i_a       (i_Rdata1),
    .i_b       (w_alu_b),
    .i_abort   (w_mul_abort),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_mul_start) w_state_next = BUSY;
      BUSY: begin
        if (i_flush)         w_state_next = IDLE;
        else if (w_mul_done) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Flush overrides the stall so the squashed slot drains immediately.
  always_comb begin
    w_mul_start = 1'b0;
    w_mul_abort = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        w_mul_start = i_valid && w_is_mul && !i_flush;
        w_stall     = w_mul_start;
      end
      BUSY: begin
        w_mul_abort = i_flush;
        w_stall     = !i_flush && w_mul_busy;
      end
      default: ;
    endcase
  end

  assign o_stall  = w_stall;
  assign w_bubble = i_flush || !i_valid || w_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_mul_done) begin
      r_hi <= w_mul_product[2*DATA_W-1:DATA_W];
      r_lo <= w_mul_product[DATA_W-1:0];
    end
  end

  // Bubbles clear the control bits but leave the datapath fields as they were.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid        <= 1'b0;
      o_MemtoReg     <= 1'b0;
      o_MemWrite     <= 1'b0;
      o_MemRead      <= 1'b0;
      o_Branch       <= 1'b0;
      o_RegWrite     <= 1'b0;
      o_BranchTarget <= '0;
      o_Zero         <= 1'b0;
      o_ALUResult    <= '0;
      o_Wdata        <= '0;
      o_WriteReg     <= '0;
    end else if (w_bubble) begin
      o_valid    <= 1'b0;
      o_MemtoReg <= 1'b0;
      o_MemWrite <= 1'b0;
      o_MemRead  <= 1'b0;
      o_Branch   <= 1'b0;
      o_RegWrite <= 1'b0;
    end else begin
      o_valid        <= 1'b1;
      o_MemtoReg     <= i_MemtoReg;
      o_MemWrite     <= i_MemWrite;
      o_MemRead      <= i_MemRead;
      o_Branch       <= i_Branch;
      o_RegWrite     <= i_RegWrite;
      o_BranchTarget <= w_branch_target;
      o_Zero         <= (w_alu_result == '0);
      o_ALUResult    <= w_alu_result;
      o_Wdata        <= i_Rdata2;
      o_WriteReg     <= i_RegDst ? i_RegDst2 : i_RegDst1;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic reference
// model of the ALU, branch target, HI/LO and multiply stall timing.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_flush;
  logic        i_MemtoReg, i_MemWrite, i_MemRead, i_Branch, i_ALUSrc, i_RegDst, i_RegWrite;
  logic [1:0]  i_ALUOp;
  logic [31:0] i_PCplus4, i_Rdata1, i_Rdata2, i_signextImmediate;
  logic [4:0]  i_RegDst1, i_RegDst2;
  logic        o_stall, o_valid, o_MemtoReg, o_MemWrite, o_MemRead, o_Branch, o_RegWrite;
  logic [31:0] o_BranchTarget, o_ALUResult, o_Wdata;
  logic        o_Zero;
  logic [4:0]  o_WriteReg;

  always #5 clk = ~clk;

  ex_stage #(.DATA_W(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_MemtoReg(i_MemtoReg), .i_MemWrite(i_MemWrite), .i_MemRead(i_MemRead),
    .i_Branch(i_Branch), .i_ALUSrc(i_ALUSrc), .i_RegDst(i_RegDst), .i_RegWrite(i_RegWrite),
    .i_ALUOp(i_ALUOp), .i_PCplus4(i_PCplus4), .i_Rdata1(i_Rdata1), .i_Rdata2(i_Rdata2),
    .i_signextImmediate(i_signextImmediate), .i_RegDst1(i_RegDst1), .i_RegDst2(i_RegDst2),
    .o_stall(o_stall), .o_valid(o_valid), .o_MemtoReg(o_MemtoReg), .o_MemWrite(o_MemWrite),
    .o_MemRead(o_MemRead), .o_Branch(o_Branch), .o_RegWrite(o_RegWrite),
    .o_BranchTarget(o_BranchTarget), .o_Zero(o_Zero), .o_ALUResult(o_ALUResult),
    .o_Wdata(o_Wdata), .o_WriteReg(o_WriteReg)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: HI/LO and the last datapath values loaded into EX/MEM.
  logic [31:0] m_hi, m_lo;
  logic [31:0] p_alu, p_bt, p_wd;
  logic [4:0]  p_wr;
  logic        p_zero, p_known;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b01) return a - b;
    if (op != 2'b10) return a + b;
    case (fn)
      6'h22, 6'h23: return a - b;
      6'h24:        return a & b;
      6'h25:        return a | b;
      6'h27:        return ~(a | b);
      6'h2A:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B:        return (a < b) ? 32'd1 : 32'd0;
      6'h10:        return m_hi;
      6'h12:        return m_lo;
      default:      return a + b;
    endcase
  endfunction

  function automatic logic [4:0] in_ctl();
    return {i_MemtoReg, i_MemWrite, i_MemRead, i_Branch, i_RegWrite};
  endfunction

  task automatic check_out(input string tag, input logic ev, input logic [4:0] ectl);
    check({tag, ".valid"}, o_valid, ev);
    check({tag, ".ctl"}, {o_MemtoReg, o_MemWrite, o_MemRead, o_Branch, o_RegWrite}, ectl);
    if (p_known) begin
      check({tag, ".alu"}, o_ALUResult, p_alu);
      check({tag, ".zero"}, o_Zero, p_zero);
    end
    check({tag, ".bt"}, o_BranchTarget, p_bt);
    check({tag, ".wdata"}, o_Wdata, p_wd);
    check({tag, ".wreg"}, o_WriteReg, p_wr);
  endtask

  task automatic load_dp();
    p_bt = i_PCplus4 + (i_signextImmediate << 2);
    p_wd = i_Rdata2;
    p_wr = i_RegDst ? i_RegDst2 : i_RegDst1;
  endtask

  task automatic set_r(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    i_valid = 1'b1; i_flush = 1'b0; i_ALUOp = 2'b10;
    i_Rdata1 = a; i_Rdata2 = b;
    i_signextImmediate = {26'($urandom), fn};
    i_PCplus4 = $urandom & 32'hFFFF_FFFC;
    i_RegDst1 = 5'($urandom); i_RegDst2 = 5'($urandom);
    {i_MemtoReg, i_MemWrite, i_MemRead, i_Branch, i_ALUSrc} = 5'b0;
    i_RegDst = 1'b1; i_RegWrite = 1'b1;
  endtask

  // One instruction that does not start a multiply.
  task automatic run_single(input string tag);
    logic ev;
    logic [31:0] b, r;
    logic [4:0] ectl;
    #1;
    check({tag, ".stall"}, o_stall, 1'b0);
    ev = i_valid && !i_flush;
    b = i_ALUSrc ? i_signextImmediate : i_Rdata2;
    r = ref_alu(i_ALUOp, i_signextImmediate[5:0], i_Rdata1, b);
    ectl = ev ? in_ctl() : 5'b0;
    if (ev) begin
      p_alu = r; p_zero = (r == 32'd0); p_known = 1'b1;
      load_dp();
    end
    @(posedge clk); #1;
    check_out(tag, ev, ectl);
    $display("[%0t] %s v=%0b fl=%0b op=%0d fn=%02h a=%08h b=%08h res=%08h",
             $time, tag, i_valid, i_flush, i_ALUOp, i_signextImmediate[5:0], i_Rdata1, b, o_ALUResult);
  endtask

  // A valid MULT/MULTU already on the inputs; optional flush or reset at BUSY cnt.
  task automatic run_mult(input string tag, input int flush_at, input int rst_at);
    logic [63:0] prod;
    logic [31:0] a, b;
    logic [4:0]  ectl;
    longint sa, sb;
    a = i_Rdata1;
    b = i_Rdata2;
    ectl = in_ctl();
    if (i_signextImmediate[5:0] == 6'h18) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      prod = 64'(sa * sb);
    end else begin
      prod = {32'h0, a} * {32'h0, b};
    end
    #1;
    check({tag, ".stall_t"}, o_stall, 1'b1);
    @(posedge clk); #1;
    check_out({tag, ".accept"}, 1'b0, 5'b0);
    for (int k = 0; k < 32; k++) begin
      if (k == flush_at) begin
        i_flush = 1'b1;
        #1;
        check({tag, ".flush_stall"}, o_stall, 1'b0);
        @(posedge clk); #1;
        check_out({tag, ".flush"}, 1'b0, 5'b0);
        i_flush = 1'b0; i_valid = 1'b0;
        $display("[%0t] %s flushed at cnt %0d", $time, tag, k);
        return;
      end
      if (k == rst_at) begin
        i_rst = 1'b1; i_valid = 1'b0;
        @(posedge clk); #1;
        i_rst = 1'b0;
        m_hi = '0; m_lo = '0;
        p_alu = '0; p_zero = 1'b0; p_bt = '0; p_wd = '0; p_wr = '0; p_known = 1'b1;
        check({tag, ".rst_stall"}, o_stall, 1'b0);
        check_out({tag, ".rst"}, 1'b0, 5'b0);
        $display("[%0t] %s reset at cnt %0d", $time, tag, k);
        return;
      end
      #1;
      check({tag, ".stall_busy"}, o_stall, 1'b1);
      @(posedge clk); #1;
      check_out({tag, ".busy"}, 1'b0, 5'b0);
    end
    #1;
    check({tag, ".stall_done"}, o_stall, 1'b0);
    load_dp();
    p_known = 1'b0;
    @(posedge clk); #1;
    m_hi = prod[63:32];
    m_lo = prod[31:0];
    check_out({tag, ".retire"}, 1'b1, ectl);
    $display("[%0t] %s a=%08h b=%08h hi=%08h lo=%08h", $time, tag, a, b, m_hi, m_lo);
  endtask

  logic [5:0] fn_tab [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
                              6'h2A, 6'h2B, 6'h10, 6'h12, 6'h18, 6'h19, 6'h00};

  initial begin
    logic [5:0] fn;
    int fl;
    m_hi = '0; m_lo = '0;
    p_alu = '0; p_zero = 1'b0; p_bt = '0; p_wd = '0; p_wr = '0; p_known = 1'b1;
    set_r(6'h20, 32'h0, 32'h0);
    i_valid = 1'b0;
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset.stall", o_stall, 1'b0);
    check_out("reset", 1'b0, 5'b0);
    i_rst = 1'b0;

    set_r(6'h20, 32'h7FFF_FFFF, 32'h1);
    run_single("add");
    check("add.const", o_ALUResult, 32'h8000_0000);
    check("add.wreg_rd", o_WriteReg, i_RegDst2);

    set_r(6'h20, 32'd5, 32'd5);
    i_ALUOp = 2'b01; i_PCplus4 = 32'h100; i_signextImmediate = 32'd3;
    i_Branch = 1'b1; i_RegWrite = 1'b0; i_RegDst = 1'b0;
    run_single("beq");
    check("beq.zero", o_Zero, 1'b1);
    check("beq.target", o_BranchTarget, 32'h10C);

    set_r(6'h18, 32'hFFFF_FFFE, 32'd3);
    i_RegWrite = 1'b0;
    run_mult("mult", -1, -1);
    set_r(6'h12, $urandom, $urandom);
    run_single("mflo");
    check("mflo.const", o_ALUResult, 32'hFFFF_FFFA);
    set_r(6'h10, $urandom, $urandom);
    run_single("mfhi");
    check("mfhi.const", o_ALUResult, 32'hFFFF_FFFF);

    set_r(6'h19, 32'hFFFF_FFFF, 32'd2);
    i_RegWrite = 1'b0;
    run_mult("multu", -1, -1);
    set_r(6'h10, $urandom, $urandom);
    run_single("mfhi_u");
    check("mfhi_u.const", o_ALUResult, 32'h1);
    set_r(6'h12, $urandom, $urandom);
    run_single("mflo_u");
    check("mflo_u.const", o_ALUResult, 32'hFFFF_FFFE);

    set_r(6'h18, $urandom, $urandom);
    i_RegWrite = 1'b0;
    run_mult("mult_flush", 10, -1);
    set_r(6'h10, $urandom, $urandom);
    run_single("mfhi_kept");
    check("mfhi_kept.const", o_ALUResult, 32'h1);
    set_r(6'h12, $urandom, $urandom);
    run_single("mflo_kept");

    set_r(6'h19, $urandom, $urandom);
    i_RegWrite = 1'b0;
    run_mult("mult_rst", -1, 10);
    set_r(6'h10, $urandom, $urandom);
    run_single("mfhi_rst");
    check("mfhi_rst.const", o_ALUResult, 32'h0);
    set_r(6'h12, $urandom, $urandom);
    run_single("mflo_rst");

    set_r(6'h2A, 32'hFFFF_FFFF, 32'h1);
    run_single("slt");
    check("slt.const", o_ALUResult, 32'h1);
    set_r(6'h2B, 32'hFFFF_FFFF, 32'h1);
    run_single("sltu");
    check("sltu.const", o_ALUResult, 32'h0);

    set_r(6'h00, 32'h0000_1000, 32'hCAFE_F00D);
    i_ALUOp = 2'b00; i_ALUSrc = 1'b1; i_signextImmediate = 32'hFFFF_FFFC;
    i_RegDst = 1'b0; i_MemRead = 1'b1; i_MemtoReg = 1'b1;
    run_single("lw");
    check("lw.addr", o_ALUResult, 32'h0000_0FFC);
    check("lw.wreg_rt", o_WriteReg, i_RegDst1);
    set_r(6'h00, 32'h0000_2000, 32'h1234_5678);
    i_ALUOp = 2'b00; i_ALUSrc = 1'b1; i_signextImmediate = 32'hFFFF_FFFC;
    i_RegWrite = 1'b0; i_MemWrite = 1'b1;
    run_single("sw");
    check("sw.addr", o_ALUResult, 32'h0000_1FFC);
    check("sw.wdata", o_Wdata, 32'h1234_5678);

    for (int it = 0; it < 300; it++) begin
      fn = fn_tab[$urandom_range(0, 13)];
      if (fn == 6'h00) fn = 6'($urandom);
      set_r(fn, $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) i_Rdata2 = i_Rdata1;
      i_ALUOp = 2'($urandom);
      {i_MemtoReg, i_MemWrite, i_MemRead, i_Branch, i_ALUSrc, i_RegDst, i_RegWrite} = 7'($urandom);
      i_valid = ($urandom_range(0, 9) != 0);
      i_flush = ($urandom_range(0, 9) == 0);
      if (i_valid && !i_flush && i_ALUOp == 2'b10 && (fn == 6'h18 || fn == 6'h19)) begin
        i_ALUSrc = 1'b0; i_RegWrite = 1'b0;
        fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
        run_mult("rnd_mul", fl, -1);
      end else begin
        run_single("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
